// File: rtl/match_collector_pkg.sv
// Shared constants, record layout and helpers for the match collector.
// Records are {eop, id}; id == NO_MATCH marks a bare end-of-packet record.
package match_collector_pkg;

    localparam int PATTERN_W  = 14;
    localparam int REC_W      = PATTERN_W + 1;
    localparam int DROP_CNT_W = 16;

    localparam logic [PATTERN_W-1:0] NO_MATCH = {PATTERN_W{1'b0}};

    typedef struct packed {
        logic                 eop;
        logic [PATTERN_W-1:0] id;
    } rec_t;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/match_collector_if.sv
// Pattern-stream input and record-output bundle of the match collector.
// The slave modport is the collector itself; master is its environment.
interface match_collector_if;

    logic [match_collector_pkg::PATTERN_W-1:0]  pattern_in;
    logic                                       pkt_start;
    logic                                       pkt_end;
    logic                                       out_ready;
    logic                                       out_valid;
    logic [match_collector_pkg::PATTERN_W-1:0]  out_pattern;
    logic                                       out_eop;
    logic                                       overflow;
    logic [match_collector_pkg::DROP_CNT_W-1:0] drop_count;

    modport slave (
        input  pattern_in, pkt_start, pkt_end, out_ready,
        output out_valid, out_pattern, out_eop, overflow, drop_count
    );

    modport master (
        output pattern_in, pkt_start, pkt_end, out_ready,
        input  out_valid, out_pattern, out_eop, overflow, drop_count
    );

endinterface

// File: rtl/match_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data shows the head while not empty.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module match_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr_s, do_rd_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_wr_s  = wr_en && (count_q < FULL_CNT);
        do_rd_s  = rd_en && (count_q != {CNT_W{1'b0}});
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/match_collector.sv
// Collects per-packet deduplicated pattern matches into a record FIFO with
// end-of-packet markers, one reserved EOP slot, and drop accounting.
module match_collector
    import match_collector_pkg::*;
#(
    parameter int DEDUP_DEPTH = 8,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    match_collector_if.slave  bus
);

    localparam int FILL_W = $clog2(DEDUP_DEPTH + 1);
    localparam int IDX_W  = $clog2(DEDUP_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [FILL_W-1:0] CAM_FULL   = FILL_W'(DEDUP_DEPTH);
    localparam logic [CNT_W-1:0]  DATA_LIMIT = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  EOP_LIMIT  = CNT_W'(FIFO_DEPTH);

    logic [PATTERN_W-1:0]   s1_pattern_q, s1_pattern_d;
    logic                   s1_start_q, s1_start_d;
    logic                   s1_end_q, s1_end_d;

    logic [DEDUP_DEPTH-1:0] cam_valid_q, cam_valid_d;
    logic [PATTERN_W-1:0]   cam_entry_q [DEDUP_DEPTH];
    logic [PATTERN_W-1:0]   cam_entry_d [DEDUP_DEPTH];
    logic [FILL_W-1:0]      fill_q, fill_d;

    logic                   overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0]  drop_count_q, drop_count_d;

    logic                   hit_s, new_id_s, insert_s;
    logic [FILL_W-1:0]      eff_fill_s;
    logic [IDX_W-1:0]       slot_s;
    logic                   rec_valid_s, accept_s, push_s, drop_s;
    rec_t                   rec_s, head_s;
    logic [REC_W-1:0]       fifo_rd_data_s;
    logic [CNT_W-1:0]       fifo_count_s;
    logic                   fifo_empty_s, pop_s;

    // Stage-1 capture of the incoming stream.
    always_comb begin
        s1_pattern_d = bus.pattern_in;
        s1_start_d   = bus.pkt_start;
        s1_end_d     = bus.pkt_end;
    end

    // Dedup compare and record formation; a packet start hides the old CAM contents.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEDUP_DEPTH; i++) begin
            hit_s = hit_s | (cam_valid_q[i] && (cam_entry_q[i] == s1_pattern_q));
        end
        hit_s       = hit_s && !s1_start_q && (s1_pattern_q != NO_MATCH);
        new_id_s    = (s1_pattern_q != NO_MATCH) && !hit_s;
        eff_fill_s  = s1_start_q ? {FILL_W{1'b0}} : fill_q;
        slot_s      = eff_fill_s[IDX_W-1:0];
        insert_s    = new_id_s && (eff_fill_s < CAM_FULL);
        rec_valid_s = new_id_s || s1_end_q;
        rec_s.eop   = s1_end_q;
        rec_s.id    = new_id_s ? s1_pattern_q : NO_MATCH;
    end

    // CAM update: optional clear on packet start, then this cycle's insert.
    always_comb begin
        cam_valid_d = s1_start_q ? {DEDUP_DEPTH{1'b0}} : cam_valid_q;
        cam_entry_d = cam_entry_q;
        fill_d      = eff_fill_s;
        if (insert_s) begin
            cam_valid_d[slot_s] = 1'b1;
            cam_entry_d[slot_s] = s1_pattern_q;
            fill_d              = eff_fill_s + FILL_W'(1);
        end else begin
            fill_d = eff_fill_s;
        end
    end

    // Admission against registered occupancy; data records leave one slot free for EOP.
    always_comb begin
        accept_s     = rec_s.eop ? (fifo_count_s < EOP_LIMIT) : (fifo_count_s < DATA_LIMIT);
        push_s       = rec_valid_s && accept_s;
        drop_s       = rec_valid_s && !accept_s;
        overflow_d   = overflow_q | drop_s;
        if (drop_s) begin
            drop_count_d = sat_inc(drop_count_q);
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    // Pipeline, CAM and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_pattern_q <= NO_MATCH;
            s1_start_q   <= 1'b0;
            s1_end_q     <= 1'b0;
            cam_valid_q  <= {DEDUP_DEPTH{1'b0}};
            for (int i = 0; i < DEDUP_DEPTH; i++) begin
                cam_entry_q[i] <= NO_MATCH;
            end
            fill_q       <= {FILL_W{1'b0}};
            overflow_q   <= 1'b0;
            drop_count_q <= {DROP_CNT_W{1'b0}};
        end else begin
            s1_pattern_q <= s1_pattern_d;
            s1_start_q   <= s1_start_d;
            s1_end_q     <= s1_end_d;
            cam_valid_q  <= cam_valid_d;
            cam_entry_q  <= cam_entry_d;
            fill_q       <= fill_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    match_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_s),
        .wr_data (rec_s),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .count   (fifo_count_s),
        .empty   (fifo_empty_s)
    );

    assign head_s          = rec_t'(fifo_rd_data_s);
    assign pop_s           = !fifo_empty_s && bus.out_ready;
    assign bus.out_valid   = !fifo_empty_s;
    assign bus.out_pattern = fifo_empty_s ? NO_MATCH : head_s.id;
    assign bus.out_eop     = fifo_empty_s ? 1'b0 : head_s.eop;
    assign bus.overflow    = overflow_q;
    assign bus.drop_count  = drop_count_q;

endmodule
